// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD display path: digit width, blank/error glyphs
// and the active-low {g,f,e,d,c,b,a} pattern table for decimal digits.
package bcd_disp_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ERR   = 7'b0000110;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to active-low segment decoder; non-decimal nibbles show 'E'.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [BCD_W-1:0] bcd_i,
  output logic [6:0]       seg_n_o
);

  always_comb begin
    seg_n_o = SEG_ERR;
    if (bcd_i <= 4'd9) seg_n_o = SEG_TABLE[bcd_i];
  end

endmodule

// File: rtl/bcd_seg7_scan.sv
// Multiplexed common-anode display scanner. Incoming words wait in a hold
// register and are committed only at a frame wrap so a frame never mixes values.
module bcd_seg7_scan
  import bcd_disp_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 1000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [BCD_W*DIGITS-1:0]   bcd_in,
  input  logic                      bcd_valid,
  output logic                      bcd_ready,
  input  logic                      blank_lz,
  output logic [6:0]                seg_n,
  output logic [DIGITS-1:0]         an_n,
  output logic                      frame_done
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WORD_W = BCD_W * DIGITS;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]  digit_idx_q, digit_idx_d;
  logic [WORD_W-1:0] disp_q, disp_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              pending_q, pending_d;
  logic [6:0]        seg_n_q, seg_n_d;
  logic [DIGITS-1:0] an_n_q, an_n_d;
  logic              frame_done_q, frame_done_d;

  logic              tick;
  logic              frame_end;
  logic              xfer;
  logic [BCD_W-1:0]  cur_nib;
  logic              cur_blank;
  logic              higher_zero;
  logic [6:0]        dec_seg;

  assign tick      = (div_cnt_q == CNT_LAST);
  assign frame_end = tick && (digit_idx_q == IDX_LAST);
  assign xfer      = bcd_valid && !pending_q;

  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + CNT_W'(1);
    digit_idx_d  = digit_idx_q;
    if (tick) digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
    hold_d       = hold_q;
    disp_d       = disp_q;
    pending_d    = pending_q;
    frame_done_d = frame_end;
    // accept needs ~pending and commit needs pending, so they are exclusive
    if (xfer) begin
      hold_d    = bcd_in;
      pending_d = 1'b1;
    end else if (frame_end && pending_q) begin
      disp_d    = hold_q;
      pending_d = 1'b0;
    end
  end

  // Walk from the top digit down so higher_zero means "this and all higher digits are 0".
  always_comb begin
    cur_nib     = '0;
    cur_blank   = 1'b0;
    higher_zero = blank_lz;
    an_n_d      = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      higher_zero = higher_zero && (disp_q[i*BCD_W +: BCD_W] == '0);
      if (digit_idx_q == IDX_W'(i)) begin
        cur_nib   = disp_q[i*BCD_W +: BCD_W];
        cur_blank = higher_zero && (i != 0);
        an_n_d[i] = cur_blank;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd_i   (cur_nib),
    .seg_n_o (dec_seg)
  );

  assign seg_n_d = cur_blank ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      digit_idx_q  <= '0;
      disp_q       <= '0;
      hold_q       <= '0;
      pending_q    <= 1'b0;
      seg_n_q      <= SEG_BLANK;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_idx_q  <= digit_idx_d;
      disp_q       <= disp_d;
      hold_q       <= hold_d;
      pending_q    <= pending_d;
      seg_n_q      <= seg_n_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bcd_ready  = !pending_q;
  assign seg_n      = seg_n_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg7_scan.sv
// Randomized bench for bcd_seg7_scan (DIGITS=4, REFRESH_DIV=4) against a
// cycle-count based model of what the display should show.
module tb_bcd_seg7_scan;

  localparam int DIG = 4;
  localparam int DIV = 4;
  localparam int FRAME = DIG * DIV;

  logic            clk;
  logic            rst;
  logic [15:0]     bcd_in;
  logic            bcd_valid;
  logic            bcd_ready;
  logic            blank_lz;
  logic [6:0]      seg_n;
  logic [3:0]      an_n;
  logic            frame_done;

  int total = 0;
  int bad   = 0;

  bcd_seg7_scan #(.DIGITS(DIG), .REFRESH_DIV(DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .bcd_valid  (bcd_valid),
    .bcd_ready  (bcd_ready),
    .blank_lz   (blank_lz),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0000110;
    endcase
  endfunction

  // returns {an_n, seg_n} for digit d of word w
  function automatic logic [10:0] render(input int w, input int d, input bit blz);
    int nib;
    bit blank;
    nib   = (w >> (4 * d)) & 15;
    blank = blz && (d > 0) && ((w >> (4 * d)) == 0);
    if (blank) return {4'hF, 7'h7F};
    return {4'hF & ~(4'(1) << d), glyph(nib)};
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((v % 10) | (((v / 10) % 10) << 4) | (((v / 100) % 10) << 8) | (((v / 1000) % 10) << 12));
  endfunction

  // Model: display position follows purely from cycles since reset.
  int          m_disp = 0;
  int          m_hold = 0;
  bit          m_pend = 0;
  int unsigned m_n    = 0;
  logic [6:0]  e_seg  = 7'h7F;
  logic [3:0]  e_an   = 4'hF;
  logic        e_fd   = 1'b0;
  logic        e_rdy  = 1'b1;

  always @(posedge clk or posedge rst) begin : model
    int d;
    bit bnd;
    if (rst) begin
      m_disp = 0; m_hold = 0; m_pend = 0; m_n = 0;
      e_seg = 7'h7F; e_an = 4'hF; e_fd = 1'b0; e_rdy = 1'b1;
    end else begin
      d   = int'((m_n / DIV) % DIG);
      bnd = ((m_n % FRAME) == FRAME - 1);
      {e_an, e_seg} = render(m_disp, d, blank_lz);
      e_fd = bnd;
      if (m_pend) begin
        if (bnd) begin
          m_disp = m_hold;
          m_pend = 0;
        end
      end else if (bcd_valid) begin
        m_hold = int'(bcd_in);
        m_pend = 1;
      end
      e_rdy = !m_pend;
      m_n++;
    end
  end

  always @(negedge clk) begin
    #1;
    chk_val("seg_n", 32'(seg_n), 32'(e_seg));
    chk_val("an_n", 32'(an_n), 32'(e_an));
    chk_val("frame_done", 32'(frame_done), 32'(e_fd));
    chk_val("bcd_ready", 32'(bcd_ready), 32'(e_rdy));
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [15:0] w);
    bit ok;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bcd_ready) begin
        bcd_in    = w;
        bcd_valid = 1'b1;
        @(negedge clk);
        bcd_valid = 1'b0;
        ok = 1;
        break;
      end
    end
    if (!ok) chk_val("load_timeout", 32'(0), 32'(1));
  endtask

  task automatic mid_reset(input int offs);
    wait_cyc(offs);
    #2 rst = 1'b1;
    #1;
    chk_val("rst_seg", 32'(seg_n), 32'h7F);
    chk_val("rst_an", 32'(an_n), 32'hF);
    chk_val("rst_ready", 32'(bcd_ready), 32'h1);
    chk_val("rst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 2))
      0:       return 16'($urandom);
      1:       return to_bcd(int'($urandom_range(0, 9999)));
      default: return to_bcd(int'($urandom_range(0, 99)));
    endcase
  endfunction

  initial begin
    int fd_cnt;
    rst       = 1'b1;
    bcd_in    = '0;
    bcd_valid = 1'b0;
    blank_lz  = 1'b0;
    wait_cyc(3);
    rst = 1'b0;

    load(16'h1234);
    wait_cyc(40);

    wait_cyc(5);
    load(16'h0042);
    chk_val("ready_while_pending", 32'(bcd_ready), 32'h0);
    wait_cyc(40);

    blank_lz = 1'b1;
    load(16'h0007); wait_cyc(40);
    load(16'h0000); wait_cyc(40);
    load(16'h0308); wait_cyc(40);
    blank_lz = 1'b0;
    load(16'h12A4); wait_cyc(40);

    fd_cnt    = 0;
    bcd_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      bcd_in = rand_word();
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    bcd_valid = 1'b0;
    chk_val("fd_per_48", 32'(fd_cnt), 32'd3);

    mid_reset(7);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      bcd_valid = ($urandom_range(0, 3) == 0);
      bcd_in    = rand_word();
      if ($urandom_range(0, 63) == 0) blank_lz = 1'($urandom);
    end
    bcd_valid = 1'b0;

    mid_reset(int'($urandom_range(1, 15)));
    wait_cyc(40);

    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
